// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Protocol: the master raises ireq_valid with a stable ireq_addr and holds both until the
// response cycle. The slave answers by pulsing iresp_ok with iresp_data in that same cycle.
// iresp_ok is ignored whenever ireq_valid is low.
interface ifetch_unit_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;

  modport master (output ireq_valid, output ireq_addr, input iresp_ok, input iresp_data);
  modport slave  (input ireq_valid, input ireq_addr, output iresp_ok, output iresp_data);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs the instruction-memory handshake,
// and folds execute-stage redirects into the next fetch address.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_enable,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  ifetch_unit_if.master       mem,
  output logic [31:0]         instruction,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                misalign,
  output logic [31:0]         fetch_cnt,
  output logic                fsm_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        fetch_start;
  logic        fetch_done;
  logic [31:0] next_addr;
  logic [31:0] ireq_addr_q;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_cnt_q;
  logic        misalign_q;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        first_fetch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_start = 1'b0;
    fetch_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_enable) begin
          fetch_start = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.iresp_ok) begin
          fetch_done = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A redirect in the start cycle bypasses the pending register; the low bits are always dropped.
  always_comb begin
    next_addr = pc_q + 32'd4;
    if (redirect_valid)   next_addr = redirect_pc;
    else if (pend_valid)  next_addr = pend_pc;
    else if (first_fetch) next_addr = PC_RESET;
    next_addr[1:0] = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ireq_addr_q <= PC_RESET;
      ir_q        <= 32'd0;
      pc_q        <= PC_RESET - 32'd4;
      fetch_cnt_q <= 32'd0;
      misalign_q  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_pc     <= 32'd0;
      first_fetch <= 1'b1;
    end else begin
      if (fetch_start) begin
        ireq_addr_q <= next_addr;
        ir_q        <= 32'd0;
        first_fetch <= 1'b0;
      end
      if (fetch_done) begin
        ir_q        <= mem.iresp_data;
        pc_q        <= ireq_addr_q;
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (fetch_start) begin
        pend_valid <= 1'b0;
      end else if (redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

  assign mem.ireq_valid = (state == S_WAIT);
  assign mem.ireq_addr  = ireq_addr_q;
  assign instruction    = ir_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misalign       = misalign_q;
  assign fetch_cnt      = fetch_cnt_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic [31:0] fetch_cnt;
  logic        fsm_state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_cnt;

  ifetch_unit_if mem_if();

  ifetch_unit #(.PC_RESET(32'hbfc0_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem            (mem_if),
    .instruction    (instruction),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .misalign       (misalign),
    .fetch_cnt      (fetch_cnt),
    .fsm_state      (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full fetch: fetch_enable for one edge, `waits` idle WAIT cycles, then the response.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] data, input int waits);
    fetch_enable = 1'b1;
    step();
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    check({tag, "_req_valid"}, {31'd0, mem_if.ireq_valid}, 32'd1);
    check({tag, "_req_addr"}, mem_if.ireq_addr, exp_addr);
    check({tag, "_ir_zero"}, instruction, 32'd0);
    for (int w = 0; w < waits; w++) begin
      fetch_enable = (w == 0);
      step();
      fetch_enable = 1'b0;
      check({tag, "_wait_valid"}, {31'd0, mem_if.ireq_valid}, 32'd1);
      check({tag, "_wait_addr"}, mem_if.ireq_addr, exp_addr);
      check({tag, "_wait_ir"}, instruction, 32'd0);
    end
    mem_if.iresp_ok   = 1'b1;
    mem_if.iresp_data = data;
    step();
    mem_if.iresp_ok   = 1'b0;
    mem_if.iresp_data = 32'd0;
    exp_cnt = exp_cnt + 32'd1;
    check({tag, "_done_valid"}, {31'd0, mem_if.ireq_valid}, 32'd0);
    check({tag, "_ir"}, instruction, data);
    check({tag, "_pc"}, pc, exp_addr);
    check({tag, "_pc_plus4"}, pc_plus4, exp_addr + 32'd4);
    check({tag, "_cnt"}, fetch_cnt, exp_cnt);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 32'd0;
    reset          = 1'b0;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_if.iresp_ok   = 1'b0;
    mem_if.iresp_data = 32'd0;
    step();
    step();

    check("rst_valid", {31'd0, mem_if.ireq_valid}, 32'd0);
    check("rst_addr", mem_if.ireq_addr, 32'hbfc0_0000);
    check("rst_ir", instruction, 32'd0);
    check("rst_pc", pc, 32'hbfbf_fffc);
    check("rst_pc_plus4", pc_plus4, 32'hbfc0_0000);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_state", {31'd0, fsm_state}, 32'd0);

    reset = 1'b1;
    step();

    do_fetch("reset_fetch", 32'hbfc0_0000, 32'h2008_0005, 0);
    do_fetch("seq_wait", 32'hbfc0_0004, 32'h2009_0007, 3);

    redirect(32'hbfc0_0100);
    step();
    do_fetch("redir_pend", 32'hbfc0_0100, 32'h1111_0001, 0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0200;
    do_fetch("redir_bypass", 32'hbfc0_0200, 32'h1111_0002, 1);

    redirect(32'hbfc0_0300);
    redirect(32'hbfc0_0400);
    do_fetch("redir_last", 32'hbfc0_0400, 32'h1111_0003, 0);
    check("misalign_clear", {31'd0, misalign}, 32'd0);

    redirect(32'hbfc0_0102);
    check("misalign_set", {31'd0, misalign}, 32'd1);
    do_fetch("misalign_fetch", 32'hbfc0_0100, 32'h1111_0004, 0);
    do_fetch("misalign_seq", 32'hbfc0_0104, 32'h1111_0005, 0);
    check("misalign_sticky", {31'd0, misalign}, 32'd1);

    fetch_enable = 1'b1;
    step();
    fetch_enable = 1'b0;
    check("abort_valid_before", {31'd0, mem_if.ireq_valid}, 32'd1);
    reset = 1'b0;
    #1;
    exp_cnt = 32'd0;
    check("abort_valid", {31'd0, mem_if.ireq_valid}, 32'd0);
    check("abort_cnt", fetch_cnt, 32'd0);
    check("abort_addr", mem_if.ireq_addr, 32'hbfc0_0000);
    check("abort_misalign", {31'd0, misalign}, 32'd0);
    step();
    reset = 1'b1;
    mem_if.iresp_ok   = 1'b1;
    mem_if.iresp_data = 32'hdead_beef;
    step();
    mem_if.iresp_ok   = 1'b0;
    mem_if.iresp_data = 32'd0;
    check("late_resp_ir", instruction, 32'd0);
    check("late_resp_cnt", fetch_cnt, 32'd0);
    check("late_resp_valid", {31'd0, mem_if.ireq_valid}, 32'd0);
    do_fetch("post_abort", 32'hbfc0_0000, 32'h2222_0001, 0);

    redirect(32'hffff_fffc);
    do_fetch("wrap_top", 32'hffff_fffc, 32'h3333_0001, 0);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    do_fetch("wrap_zero", 32'h0000_0000, 32'h3333_0002, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
